// File: rtl/led_message_sequencer.sv
// Buffers a message of 5-bit letter codes and plays each one on blue_led for (code+1) seconds.
// Optional feature macro LED_SEQ_REPEAT_EN adds i_repeat_mode for continuous looping playback.
module led_message_sequencer #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int MAX_LEN   = 16,
    parameter int GAP_TICKS = 1,
    localparam int IW       = $clog2(MAX_LEN)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr_valid,
    output logic          o_wr_ready,
    input  logic [4:0]    i_wr_data,
    input  logic          i_clear,
    input  logic          i_start,
    input  logic          i_abort,
`ifdef LED_SEQ_REPEAT_EN
    input  logic          i_repeat_mode,
`endif
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err_code,
    output logic [IW-1:0] o_cur_index,
    output logic          o_blue_led
);

    // state | meaning
    // IDLE  | accepting writes/clear/start, LED dark
    // ON    | LED lit for (code+1) ticks of the current letter
    // ON    |
    // GAP   | LED dark for GAP_TICKS ticks before the next letter
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int PW     = $clog2(TICK_DIV);
    localparam int GAP_W  = $clog2(GAP_TICKS + 1);
    localparam int TW     = (GAP_W > 6) ? GAP_W : 6;
    localparam int LW     = IW + 1;

    state_t          r_state;
    logic [LW-1:0]   r_len;
    logic [IW-1:0]   r_idx;
    logic [PW-1:0]   r_psc;
    logic [TW-1:0]   r_tick;
    logic            r_led;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [4:0]      r_buf [MAX_LEN];

    logic            w_idle;
    logic            w_full;
    logic            w_wr_fire;
    logic            w_code_ok;
    logic            w_psc_wrap;
    logic [4:0]      w_code;
    logic            w_on_end;
    logic            w_gap_end;
    logic            w_last;
    logic            w_repeat;

`ifdef LED_SEQ_REPEAT_EN
    assign w_repeat = i_repeat_mode;
`else
    assign w_repeat = 1'b0;
`endif

    assign w_idle     = (r_state == S_IDLE);
    assign w_full     = (r_len == LW'(MAX_LEN));
    assign o_wr_ready = w_idle && !w_full && !i_start;
    assign w_wr_fire  = i_wr_valid && o_wr_ready && !i_clear;
    assign w_code_ok  = (i_wr_data <= 5'd25);

    assign w_psc_wrap = (r_psc == PW'(TICK_DIV - 1));
    assign w_code     = r_buf[r_idx];
    assign w_on_end   = w_psc_wrap && ((r_tick + TW'(1)) == (TW'(w_code) + TW'(1)));
    assign w_gap_end  = w_psc_wrap && ((r_tick + TW'(1)) == TW'(GAP_TICKS));
    assign w_last     = ({1'b0, r_idx} == (r_len - LW'(1)));

    // Letter storage is not reset; only len defines which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_wr_fire && w_code_ok) begin
            r_buf[r_len[IW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_psc   <= '0;
            r_tick  <= '0;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (r_state == S_ON || r_state == S_GAP) begin
                if (w_psc_wrap) begin
                    r_psc  <= '0;
                    r_tick <= r_tick + TW'(1);
                end else begin
                    r_psc  <= r_psc + PW'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_busy <= 1'b1;
                        r_idx  <= '0;
                        if (r_len != '0) begin
                            r_state <= S_ON;
                            r_led   <= 1'b1;
                            r_psc   <= '0;
                            r_tick  <= '0;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else if (i_clear) begin
                        r_len <= '0;
                    end else if (w_wr_fire) begin
                        if (w_code_ok) begin
                            r_len <= r_len + LW'(1);
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_ON: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_led   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                    end else if (w_on_end) begin
                        r_led <= 1'b0;
                        if (!w_last || w_repeat) begin
                            r_state <= S_GAP;
                            r_psc   <= '0;
                            r_tick  <= '0;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_led   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                    end else if (w_gap_end) begin
                        r_state <= S_ON;
                        r_led   <= 1'b1;
                        r_psc   <= '0;
                        r_tick  <= '0;
                        // A gap after the last letter only happens when looping.
                        r_idx   <= w_last ? '0 : r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_led   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err_code  = r_err;
    assign o_cur_index = r_idx;
    assign o_blue_led  = r_led;

endmodule

// File: tb/tb_led_message_sequencer.sv
// Bench for led_message_sequencer: vector table, hand-written corner sequences and
// randomized messages checked against a letter-queue model of the expected LED waveform.
module tb_led_message_sequencer;

    localparam int TD = 4;
    localparam int ML = 4;
    localparam int GT = 1;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [4:0]    wr_data;
    logic          clear;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          err_code;
    logic [IW-1:0] cur_index;
    logic          blue_led;
`ifdef LED_SEQ_REPEAT_EN
    logic          repeat_mode = 1'b0;
`endif

    led_message_sequencer #(.TICK_DIV(TD), .MAX_LEN(ML), .GAP_TICKS(GT)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_wr_data   (wr_data),
        .i_clear     (clear),
        .i_start     (start),
        .i_abort     (abort),
`ifdef LED_SEQ_REPEAT_EN
        .i_repeat_mode(repeat_mode),
`endif
        .o_busy      (busy),
        .o_done      (done),
        .o_err_code  (err_code),
        .o_cur_index (cur_index),
        .o_blue_led  (blue_led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int model_q[$];

    typedef struct {
        logic       wv;
        logic [4:0] wd;
        logic       clr;
        logic       st;
        logic       exp_ready;
        logic       exp_err;
        logic       exp_done;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_st(input string nm, input logic led, input logic b, input logic d,
                          input logic rdy, input int idx, input bit idx_care);
        logic [IW-1:0] ai;
        logic [IW-1:0] ei;
        ai = idx_care ? cur_index : '0;
        ei = idx_care ? IW'(idx) : '0;
        chk(nm, {26'd0, blue_led, busy, done, wr_ready, ai}, {26'd0, led, b, d, rdy, ei});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_step(input int code, input bit doclr);
        bit exp_rdy;
        wr_valid = 1'b1;
        wr_data  = 5'(code);
        clear    = doclr;
        #1;
        exp_rdy = (model_q.size() < ML);
        chk("wr_ready", {31'd0, wr_ready}, {31'd0, exp_rdy});
        cyc();
        chk("err_code", {31'd0, err_code}, {31'd0, (!doclr && exp_rdy && code > 25)});
        if (doclr) model_q.delete();
        else if (exp_rdy && code <= 25) model_q.push_back(code);
        wr_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic clear_all();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        model_q.delete();
    endtask

    // Expected waveform derived directly from the letter list: (code+1)*TD lit cycles per
    // letter, GT*TD dark cycles between letters, then one done cycle.
    task automatic play_check(input string nm);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < model_q.size(); i++) begin
            for (int k = 0; k < (model_q[i] + 1) * TD; k++) begin
                chk_st({nm, "_on"}, 1'b1, 1'b1, 1'b0, 1'b0, i, 1'b1);
                cyc();
            end
            if (i != model_q.size() - 1) begin
                for (int k = 0; k < GT * TD; k++) begin
                    chk_st({nm, "_gap"}, 1'b0, 1'b1, 1'b0, 1'b0, i, 1'b1);
                    cyc();
                end
            end
        end
        chk_st({nm, "_done"}, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        cyc();
        chk_st({nm, "_idle"}, 1'b0, 1'b0, 1'b0, (model_q.size() < ML), 0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        vecs[0]  = '{1'b1, 5'd30, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'd1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 5'd25, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; wr_valid = 1'b0; wr_data = '0; clear = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_st("reset_state", 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        chk("reset_err", {31'd0, err_code}, 32'd0);
        reset = 1'b0;
        cyc();

        // Write / invalid / full / clear behaviour
        for (int i = 0; i < 14; i++) begin
            wr_valid = vecs[i].wv;
            wr_data  = vecs[i].wd;
            clear    = vecs[i].clr;
            start    = vecs[i].st;
            #1;
            chk($sformatf("vec%0d_ready", i), {31'd0, wr_ready}, {31'd0, vecs[i].exp_ready});
            cyc();
            chk($sformatf("vec%0d_err", i), {31'd0, err_code}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vecs[i].exp_done});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            chk($sformatf("vec%0d_led", i), {31'd0, blue_led}, 32'd0);
            wr_valid = 1'b0; clear = 1'b0; start = 1'b0;
        end
        model_q.delete();

        // Two-letter message: 12 lit, 4 dark, 4 lit, done
        write_step(2, 1'b0);
        write_step(0, 1'b0);
        play_check("msg_2_0");

        // Full buffer playback, including letter z
        clear_all();
        write_step(25, 1'b0);
        write_step(1, 1'b0);
        write_step(0, 1'b0);
        write_step(3, 1'b0);
        write_step(9, 1'b0);
        play_check("msg_full");

        // Abort on the 10th lit cycle; writes while busy are ignored
        clear_all();
        write_step(25, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk_st("abort_pre", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
            if (k == 5) begin
                wr_valid = 1'b1;
                wr_data  = 5'd3;
            end
            if (k == 10) abort = 1'b1;
            cyc();
            wr_valid = 1'b0;
        end
        abort = 1'b0;
        chk_st("abort_post", 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk_st("abort_quiet", 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        end
        play_check("abort_replay");

        // Abort while in a gap
        clear_all();
        write_step(0, 1'b0);
        write_step(1, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (TD + 1) cyc();
        chk_st("gap_abort_pre", 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk_st("gap_abort_post", 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);

        // Asynchronous reset mid-ON
        clear_all();
        write_step(25, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (6) cyc();
        chk("rst_pre_led", {31'd0, blue_led}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_st("async_reset", 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        #1;
        reset = 1'b0;
        cyc();
        model_q.delete();
        play_check("post_reset_empty");

`ifdef LED_SEQ_REPEAT_EN
        clear_all();
        write_step(0, 1'b0);
        repeat_mode = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int l = 0; l < 3; l++) begin
            for (int k = 0; k < TD; k++) begin
                chk_st("rep_on", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
                cyc();
            end
            for (int k = 0; k < GT * TD; k++) begin
                chk_st("rep_gap", 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
                cyc();
            end
        end
        repeat_mode = 1'b0;
        for (int k = 0; k < TD; k++) begin
            chk_st("rep_last_on", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
            cyc();
        end
        chk_st("rep_done", 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        cyc();
        chk_st("rep_idle", 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
`endif

        // Randomized messages
        for (int it = 0; it < 10; it++) begin
            int n_wr;
            clear_all();
            n_wr = $urandom_range(0, 6);
            for (int w = 0; w < n_wr; w++) begin
                int code;
                bit doclr;
                code  = ($urandom_range(0, 5) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
                doclr = ($urandom_range(0, 9) == 0);
                write_step(code, doclr);
                if ($urandom_range(0, 2) == 0) cyc();
            end
            play_check($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
